pixel_plotter: RTL and testbench

- Downstream of the shape renderers: consumes the (x, y) pixel stream a renderer emits while enabled, tags it with a colour, clips it to the screen, and converts it to a linear framebuffer address.
- Buffers pixels in a small FIFO and issues writes to the framebuffer port under a valid/ready handshake.
- Pulses done when the last pixel of a shape has been written or discarded, so the scene sequencer can start the next element.

---
 rtl/pixel_plotter_pkg.sv | 34 +++
 rtl/pixel_fifo.sv | 55 +++++
 rtl/pixel_plotter.sv | 118 +++++++++++
 tb/tb_pixel_plotter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_plotter_pkg.sv
// Shared screen geometry, coordinate widths and the pixel entry format
// used by the plotter pipeline and the shape renderers.
package pixel_plotter_pkg;

    localparam int X_BITS              = 8;
    localparam int Y_BITS              = 7;
    localparam int SCREEN_W            = 160;
    localparam int SCREEN_H            = 120;
    localparam int COLOUR_BITS         = 3;
    localparam int ADDR_BITS           = 15;
    localparam int DEFAULT_FIFO_DEPTH  = 4;
    localparam int CLIP_COUNT_BITS     = 16;

    // One buffered pixel; write_flag=0 marks a clipped pixel kept only for ordering.
    typedef struct packed {
        logic                   last;
        logic                   write_flag;
        logic [COLOUR_BITS-1:0] colour;
        logic [ADDR_BITS-1:0]   addr;
    } pixel_entry_t;

    localparam int ENTRY_BITS = $bits(pixel_entry_t);

    function automatic logic on_screen(input logic [X_BITS-1:0] x,
                                       input logic [Y_BITS-1:0] y);
        return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
    endfunction

    function automatic logic [ADDR_BITS-1:0] linear_addr(input logic [X_BITS-1:0] x,
                                                         input logic [Y_BITS-1:0] y);
        return ADDR_BITS'(y) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(x);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata always shows the head entry.
module pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pixel_plotter.sv
// Clips, addresses and buffers renderer pixels, then writes them to the
// framebuffer under valid/ready; pulses done when a shape's last pixel retires.
module pixel_plotter
    import pixel_plotter_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [X_BITS-1:0]          in_x,
    input  logic [Y_BITS-1:0]          in_y,
    input  logic [COLOUR_BITS-1:0]     in_colour,
    input  logic                       in_last,
    output logic                       fb_we,
    input  logic                       fb_ready,
    output logic [ADDR_BITS-1:0]       fb_addr,
    output logic [COLOUR_BITS-1:0]     fb_data,
    output logic                       done,
    output logic [CLIP_COUNT_BITS-1:0] clipped_count
);

    localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

    pixel_entry_t   in_entry;
    logic           accept;

    logic           as_valid;
    pixel_entry_t   as_entry;

    logic [ENTRY_BITS-1:0] fifo_head_bits;
    pixel_entry_t   fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic           fifo_pop;
    logic [CNT_W:0] occupancy;

    logic           out_valid;
    pixel_entry_t   out_entry;
    logic           out_retire;
    logic           out_load;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        in_entry            = '0;
        in_entry.last       = in_last;
        in_entry.write_flag = on_screen(in_x, in_y);
        in_entry.colour     = in_colour;
        in_entry.addr       = linear_addr(in_x, in_y);
    end

    // The output register is deliberately excluded from the slot count.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, as_valid};
    assign in_ready  = !fifo_full && (occupancy < DEPTH_L);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            as_valid      <= 1'b0;
            as_entry      <= '0;
            clipped_count <= '0;
        end else begin
            as_valid <= accept;
            if (accept) begin
                as_entry <= in_entry;
                if (!in_entry.write_flag && (clipped_count != '1)) begin
                    clipped_count <= clipped_count + CLIP_COUNT_BITS'(1);
                end
            end
        end
    end

    pixel_fifo #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (as_valid),
        .pop    (fifo_pop),
        .wdata  (as_entry),
        .rdata  (fifo_head_bits),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign fifo_head = pixel_entry_t'(fifo_head_bits);

    // Clipped entries spend one cycle here with fb_we low, then retire unconditionally.
    assign out_retire = out_valid && (!out_entry.write_flag || fb_ready);
    assign out_load   = !out_valid || out_retire;
    assign fifo_pop   = out_load && !fifo_empty;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_entry <= '0;
            done      <= 1'b0;
        end else begin
            done <= out_retire && out_entry.last;
            if (out_load) begin
                out_valid <= !fifo_empty;
                if (!fifo_empty) begin
                    out_entry <= fifo_head;
                end
            end
        end
    end

    assign fb_we   = out_valid && out_entry.write_flag;
    assign fb_addr = out_entry.addr;
    assign fb_data = out_entry.colour;

endmodule

// File: tb/tb_pixel_plotter.sv
// Directed and randomised bench for pixel_plotter with an in-order expected-event model.
module tb_pixel_plotter;
    import pixel_plotter_pkg::*;

    localparam int DEPTH = DEFAULT_FIFO_DEPTH;

    logic                       clock = 1'b0;
    logic                       resetn = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [X_BITS-1:0]          in_x = '0;
    logic [Y_BITS-1:0]          in_y = '0;
    logic [COLOUR_BITS-1:0]     in_colour = '0;
    logic                       in_last = 1'b0;
    logic                       fb_we;
    logic                       fb_ready = 1'b0;
    logic [ADDR_BITS-1:0]       fb_addr;
    logic [COLOUR_BITS-1:0]     fb_data;
    logic                       done;
    logic [CLIP_COUNT_BITS-1:0] clipped_count;

    pixel_plotter dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_colour     (in_colour),
        .in_last       (in_last),
        .fb_we         (fb_we),
        .fb_ready      (fb_ready),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .done          (done),
        .clipped_count (clipped_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Expected observable events in order: framebuffer writes and done pulses.
    typedef struct {
        bit is_done;
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   clip_exp     = 0;
    int   n_writes     = 0;
    int   last_wr_addr = -1;

    function automatic void model_accept(input int x, input int y, input int c, input bit last);
        exp_t e;
        if (x < 160 && y < 120) begin
            e.is_done = 1'b0;
            e.addr    = y * 160 + x;
            e.data    = c;
            exp_q.push_back(e);
        end else if (clip_exp < 65535) begin
            clip_exp++;
        end
        if (last) begin
            e.is_done = 1'b1;
            e.addr    = 0;
            e.data    = 0;
            exp_q.push_back(e);
        end
    endfunction

    bit ready_rand  = 1'b0;
    bit ready_force = 1'b1;

    always @(posedge clock) begin
        #1;
        fb_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    bit stall_prev = 1'b0;
    int held_addr  = 0;
    int held_data  = 0;

    always @(negedge clock) begin
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_we", int'(fb_we), 1);
                check("hold_addr", int'(fb_addr), held_addr);
                check("hold_data", int'(fb_data), held_data);
            end
            if (done) begin
                check("done_order", int'(exp_q.size() > 0 && exp_q[0].is_done), 1);
                if (exp_q.size() > 0 && exp_q[0].is_done) void'(exp_q.pop_front());
            end
            if (fb_we && fb_ready) begin
                check("write_order", int'(exp_q.size() > 0 && !exp_q[0].is_done), 1);
                if (exp_q.size() > 0 && !exp_q[0].is_done) begin
                    check("write_addr", int'(fb_addr), exp_q[0].addr);
                    check("write_data", int'(fb_data), exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                n_writes++;
                last_wr_addr = int'(fb_addr);
            end
            stall_prev = fb_we && !fb_ready;
            held_addr  = int'(fb_addr);
            held_data  = int'(fb_data);
        end
    end

    // Presents one pixel until accepted; returns the number of cycles it waited.
    task automatic send(input int x, input int y, input int c, input bit last, output int waits);
        bit acc;
        waits     = 0;
        in_valid  = 1'b1;
        in_x      = X_BITS'(x);
        in_y      = Y_BITS'(y);
        in_colour = COLOUR_BITS'(c);
        in_last   = last;
        do begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) model_accept(x, y, c, last);
            else waits++;
        end while (!acc && waits < 200);
        if (!acc) check("send_timeout", waits, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clock);
            c++;
        end
        repeat (3) @(posedge clock);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int w;
        int stalls;
        int base_writes;
        int base_clip;
        int accepted;
        bit acc;

        // Reset state
        #3;
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        check("rst_done", int'(done), 0);
        check("rst_clipped", int'(clipped_count), 0);
        #19 resetn = 1'b1;
        @(posedge clock);
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Single pixel: accepted at edge N, write visible after edge N+2, done after N+3
        send(3, 2, 5, 1'b1, w);
        @(negedge clock);
        check("t1_we_n0", int'(fb_we), 0);
        @(negedge clock);
        check("t1_we_n1", int'(fb_we), 0);
        @(negedge clock);
        check("t1_we_n2", int'(fb_we), 1);
        check("t1_addr", int'(fb_addr), 323);
        check("t1_data", int'(fb_data), 5);
        check("t1_done_early", int'(done), 0);
        @(negedge clock);
        check("t1_done", int'(done), 1);
        @(negedge clock);
        check("t1_done_pulse", int'(done), 0);
        drain("t1_drain");

        // 10x10 block from the origin at full rate
        stalls      = 0;
        base_writes = n_writes;
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                send(x, y, (x + y) % 8, (x == 9 && y == 9), w);
                stalls += w;
            end
        end
        drain("t2_drain");
        check("t2_no_stall", stalls, 0);
        check("t2_writes", n_writes - base_writes, 100);
        check("t2_last_addr", last_wr_addr, 1449);

        // Screen-edge corner and one-past-edge clipping
        base_writes = n_writes;
        send(159, 119, 6, 1'b0, w);
        send(160, 0, 2, 1'b0, w);
        send(0, 120, 3, 1'b1, w);
        drain("t3_drain");
        check("t3_writes", n_writes - base_writes, 1);
        check("t3_corner_addr", last_wr_addr, 19199);
        check("t3_clipped", int'(clipped_count), 2);
        check("t3_clip_model", int'(clipped_count), clip_exp);

        // Back-pressure: the FIFO slots plus the stalled output register fill up
        ready_force = 1'b0;
        @(posedge clock);
        #1;
        accepted = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid  = 1'b1;
            in_x      = X_BITS'(20 + accepted);
            in_y      = Y_BITS'(5);
            in_colour = COLOUR_BITS'(accepted % 8);
            in_last   = (accepted == DEPTH);
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
            if (acc) begin
                model_accept(20 + accepted, 5, accepted % 8, accepted == DEPTH);
                accepted++;
            end
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("t4_in_ready_low", int'(in_ready), 0);
        check("t4_accepted", accepted, DEPTH + 1);
        ready_force = 1'b1;
        drain("t4_drain");

        // Reset with three pixels pending
        ready_force = 1'b0;
        @(posedge clock);
        #1;
        send(1, 1, 1, 1'b0, w);
        send(200, 1, 2, 1'b0, w);
        send(2, 1, 3, 1'b1, w);
        repeat (2) @(posedge clock);
        #1;
        base_writes = n_writes;
        resetn = 1'b0;
        #1;
        check("t5_we_zero", int'(fb_we), 0);
        check("t5_addr_zero", int'(fb_addr), 0);
        check("t5_data_zero", int'(fb_data), 0);
        check("t5_done_zero", int'(done), 0);
        check("t5_clip_zero", int'(clipped_count), 0);
        exp_q.delete();
        clip_exp = 0;
        ready_force = 1'b1;
        #5 resetn = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("t5_no_stale_writes", n_writes - base_writes, 0);
        send(7, 7, 6, 1'b1, w);
        drain("t5_drain");
        check("t5_next_addr", last_wr_addr, 1127);

        // Random stream with random back-pressure and 10% off-screen pixels
        ready_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int x;
            int y;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin x = $urandom_range(160, 255); y = $urandom_range(0, 119); end
                    1: begin x = $urandom_range(0, 159);   y = $urandom_range(120, 127); end
                    default: begin x = $urandom_range(160, 255); y = $urandom_range(120, 127); end
                endcase
            end else begin
                x = $urandom_range(0, 159);
                y = $urandom_range(0, 119);
            end
            repeat ($urandom_range(0, 1)) @(posedge clock);
            #1;
            send(x, y, $urandom_range(0, 7), (i % 50 == 49), w);
        end
        drain("t6_drain");
        check("t6_clipped", int'(clipped_count), clip_exp);
        ready_rand = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
